// File: rtl/player_hit_judge.sv
// player_hit_judge: player/enemy-bullet collision, health, invulnerability and explosion sequencing
module player_hit_judge #(
  parameter int PLANE_W      = 50,
  parameter int PLANE_H      = 40,
  parameter int BULLET_W     = 10,
  parameter int BULLET_H     = 10,
  parameter int MAX_HEALTH   = 3,
  parameter int INVULN_TICKS = 60,
  parameter int FRAME_TICKS  = 8,
  parameter int BOOM_FRAMES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [9:0] p_x,
  input  logic [9:0] p_y,
  input  logic [9:0] eb_x,
  input  logic [9:0] eb_y,
  input  logic       ebullet_en,
  input  logic       player_en,
  output logic       hit,
  output logic [2:0] health,
  output logic       invuln,
  output logic       boom,
  output logic [1:0] boom_frame,
  output logic       dead
);
  typedef enum logic [2:0] {IDLE, ALIVE, INVULN, BOOM, DEAD} state_t;
  localparam int IW = $clog2(INVULN_TICKS + 1);
  localparam int FW = $clog2(FRAME_TICKS + 1);
  state_t state, state_n;
  logic [2:0] health_n;
  logic hit_n, coll, qhit;
  logic [IW-1:0] inv_cnt, inv_n;
  logic [FW-1:0] tcnt, tcnt_n;
  logic [1:0] frame, frame_n;
  assign coll = ({1'b0, eb_x} + 11'(BULLET_W) > {1'b0, p_x}) && ({1'b0, eb_x} < {1'b0, p_x} + 11'(PLANE_W)) &&
                ({1'b0, eb_y} + 11'(BULLET_H) > {1'b0, p_y}) && ({1'b0, eb_y} < {1'b0, p_y} + 11'(PLANE_H));
  assign qhit = coll && ebullet_en && player_en && state == ALIVE;
  always_comb begin
    state_n  = state;
    health_n = health;
    hit_n    = 1'b0;
    inv_n    = inv_cnt;
    tcnt_n   = tcnt;
    frame_n  = frame;
    case (state)
      IDLE: state_n = player_en ? ALIVE : IDLE;
      ALIVE: if (qhit) begin
        hit_n = 1'b1;
        if (health > 3'd1) begin
          health_n = health - 3'd1;
          inv_n    = IW'(INVULN_TICKS);
          state_n  = INVULN;
        end else begin
          health_n = 3'd0;
          tcnt_n   = '0;
          frame_n  = 2'd0;
          state_n  = BOOM;
        end
      end
      INVULN: if (player_en && tick) begin
        inv_n   = inv_cnt - 1'b1;
        state_n = inv_cnt == IW'(1) ? ALIVE : INVULN;
      end
      BOOM: if (tick) begin
        if (tcnt == FW'(FRAME_TICKS - 1)) begin
          tcnt_n = '0;
          if (frame == 2'(BOOM_FRAMES - 1)) state_n = DEAD;
          else frame_n = frame + 2'd1;
        end else tcnt_n = tcnt + 1'b1;
      end
      DEAD: state_n = DEAD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      health  <= 3'(MAX_HEALTH);
      hit     <= 1'b0;
      inv_cnt <= '0;
      tcnt    <= '0;
      frame   <= 2'd0;
    end else begin
      state   <= state_n;
      health  <= health_n;
      hit     <= hit_n;
      inv_cnt <= inv_n;
      tcnt    <= tcnt_n;
      frame   <= frame_n;
    end
  end
  assign invuln     = state == INVULN;
  assign boom       = state == BOOM;
  assign dead       = state == DEAD;
  assign boom_frame = boom ? frame : 2'd0;
endmodule

// File: tb/tb_player_hit_judge.sv
// tb_player_hit_judge: directed checks of collision edges, gating, invulnerability, explosion and reset
module tb_player_hit_judge;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, ebullet_en = 1'b0, player_en = 1'b0;
  logic [9:0] p_x = 10'd100, p_y = 10'd400, eb_x = 10'd0, eb_y = 10'd0;
  logic hit, invuln, boom, dead;
  logic [2:0] health;
  logic [1:0] boom_frame;
  int checks = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  player_hit_judge #(.INVULN_TICKS(3), .FRAME_TICKS(2), .BOOM_FRAMES(4), .MAX_HEALTH(3)) dut (
    .clk(clk), .rst(rst), .tick(tick), .p_x(p_x), .p_y(p_y), .eb_x(eb_x), .eb_y(eb_y),
    .ebullet_en(ebullet_en), .player_en(player_en), .hit(hit), .health(health),
    .invuln(invuln), .boom(boom), .boom_frame(boom_frame), .dead(dead));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clk1();
    @(posedge clk);
    #1;
    cyc++;
    tick = (cyc % 4) == 3;
  endtask
  task automatic run_hits(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      clk1();
      hits += int'(hit);
    end
  endtask
  task automatic wait_hit(input string tag);
    int g = 0;
    while (!hit && g < 100) begin
      clk1();
      g++;
    end
    chk(tag, int'(hit), 1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    clk1();
    clk1();
    rst = 1'b0;
  endtask
  task automatic place(input int x, input int y, input logic en);
    eb_x = 10'(x);
    eb_y = 10'(y);
    ebullet_en = en;
  endtask
  initial begin
    int h, n, g;
    logic t;
    do_reset();
    chk("rst_health", int'(health), 3);
    chk("rst_hit", int'(hit), 0);
    chk("rst_invuln", int'(invuln), 0);
    chk("rst_boom", int'(boom), 0);
    chk("rst_frame", int'(boom_frame), 0);
    chk("rst_dead", int'(dead), 0);
    player_en = 1'b1;
    clk1();
    place(150, 410, 1'b1);
    run_hits(8, h);
    chk("edge_right", h, 0);
    place(90, 410, 1'b1);
    run_hits(8, h);
    chk("edge_left", h, 0);
    place(120, 410, 1'b0);
    run_hits(8, h);
    chk("gate_eben", h, 0);
    place(1000, 1000, 1'b1);
    run_hits(8, h);
    chk("wrap", h, 0);
    place(120, 410, 1'b1);
    player_en = 1'b0;
    run_hits(8, h);
    chk("gate_pen", h, 0);
    chk("gate_pen_health", int'(health), 3);
    chk("gate_pen_invuln", int'(invuln), 0);
    player_en = 1'b1;
    place(91, 410, 1'b1);
    wait_hit("single_hit");
    chk("single_health", int'(health), 2);
    chk("single_invuln", int'(invuln), 1);
    ebullet_en = 1'b0;
    clk1();
    chk("hit_one_cycle", int'(hit), 0);
    n = int'(tick && 1'b0);
    n = 0;
    g = 0;
    h = 0;
    while (invuln && g < 100) begin
      t = tick;
      clk1();
      if (t) n++;
      h += int'(hit);
      g++;
    end
    chk("invuln_ticks", n, 3);
    chk("invuln_nohit", h, 0);
    chk("after_invuln_health", int'(health), 2);
    do_reset();
    player_en = 1'b1;
    place(120, 410, 1'b1);
    clk1();
    chk("idle_no_hit", int'(hit), 0);
    h = 0;
    for (int i = 0; i < 20; i++) begin
      clk1();
      h += int'(hit);
      if (i == 0) chk("held_first_hit", int'(hit), 1);
    end
    chk("held_hits", h, 2);
    chk("held_health", int'(health), 1);
    wait_hit("fatal_hit");
    chk("fatal_health", int'(health), 0);
    chk("fatal_boom", int'(boom), 1);
    chk("fatal_frame0", int'(boom_frame), 0);
    n = 0;
    g = 0;
    h = 0;
    while (!dead && g < 200) begin
      t = tick;
      clk1();
      h += int'(hit);
      if (t) begin
        n++;
        if (!dead) chk($sformatf("frame_t%0d", n), int'(boom_frame), n / 2);
      end
      g++;
    end
    chk("boom_ticks", n, 8);
    chk("boom_nohit", h, 0);
    chk("dead", int'(dead), 1);
    chk("dead_boom", int'(boom), 0);
    chk("dead_frame", int'(boom_frame), 0);
    run_hits(12, h);
    chk("dead_nohit", h, 0);
    chk("dead_sticky", int'(dead), 1);
    chk("dead_health", int'(health), 0);
    do_reset();
    player_en = 1'b1;
    place(120, 410, 1'b1);
    g = 0;
    while (!(boom && boom_frame == 2'd2) && g < 300) begin
      clk1();
      g++;
    end
    chk("reach_frame2", int'(boom_frame), 2);
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    chk("midrst_health", int'(health), 3);
    chk("midrst_boom", int'(boom), 0);
    chk("midrst_frame", int'(boom_frame), 0);
    chk("midrst_dead", int'(dead), 0);
    chk("midrst_invuln", int'(invuln), 0);
    chk("midrst_hit", int'(hit), 0);
    clk1();
    chk("midrst_idle", int'(hit), 0);
    clk1();
    chk("midrst_rehit", int'(hit), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
